vid_lock: RTL and testbench
===========================

VID_LOCK -- requirements
Module: vid_lock

Interface
REQ-001 SHALL have parameter H_WIDTH, default 1920, expected active pixels (de_i high cycles) per line.
REQ-002 SHALL have parameter H_TOTAL, default 2200, expected clocks between consecutive hs_i rising edges.
REQ-003 SHALL have parameter V_HEIGHT, default 1080, expected active lines (de_i rising edges) per frame.
REQ-004 SHALL have parameter LOCK_FRAMES, default 4, consecutive good frames required to lock.
REQ-005 SHALL have parameter TIMEOUT, default 2*H_TOTAL, clocks without an hs_i rising edge before forced unlock.
REQ-006 SHALL have port clk_i, input, 1, pixel clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-008 SHALL have ports hs_i, vs_i, de_i, input, 1 each, video timing, active-high.
REQ-009 SHALL have port locked_o, output, 1, timing matches parameters.
REQ-010 SHALL have port frame_o, output, 1, one-cycle pulse per vs_i rising edge.
REQ-011 SHALL have port err_o, output, 1, one-cycle pulse on a bad frame or timeout.
REQ-012 SHALL have ports h_width_o, h_total_o, v_height_o, output, 12 each, last measured values.

Function
REQ-013 SHALL register hs_i, vs_i and de_i once; edges are detected from the registered value versus its previous value.
REQ-014 SHALL count de-high cycles per line, compare the count with H_WIDTH at each de falling edge, and latch a frame-bad flag on mismatch.
REQ-015 SHALL count clocks between hs rising edges and compare with H_TOTAL at each hs rise, except the first hs rise after reset or timeout.
REQ-016 SHALL count de rising edges per frame; a de rise in the same cycle as a vs rise counts toward the new frame.
REQ-017 SHALL saturate all counters at 4095 (no wrap-around); a saturated count is a mismatch.
REQ-018 SHALL, at each vs rise, copy the last line width, last hs period and frame line count to h_width_o, h_total_o and v_height_o; pulse frame_o; evaluate the frame; then clear the frame-bad flag and the line count.
REQ-019 SHALL define a good frame as: line count equals V_HEIGHT and the frame-bad flag is clear.
REQ-020 SHALL implement the FSM states UNLOCKED, CHECKING and LOCKED, with a good-frame counter.
REQ-021 SHALL, in UNLOCKED, move to CHECKING with counter 0 on a vs rise, discarding the partial frame.
REQ-022 SHALL, in CHECKING: on a good frame, increment the counter and enter LOCKED when the counter reaches LOCK_FRAMES; on a bad frame, reset the counter to 0 and pulse err_o.
REQ-023 SHALL, in LOCKED: on a bad frame, go to CHECKING with counter 0 and pulse err_o.
REQ-024 SHALL, in any state, go to UNLOCKED and pulse err_o when TIMEOUT clocks pass without an hs rise; only one err_o pulse per timeout episode.
REQ-025 SHALL drive locked_o high only in LOCKED, registered, so it rises on the clock edge after the vs rise that completes the lock.
REQ-026 SHALL give frame_o and err_o a latency of one clock after the cycle in which the registered vs edge is seen.
REQ-027 SHALL give a timeout precedence over a frame evaluation in the same cycle.

Reset
REQ-028 SHALL, on rst_i high, immediately clear all outputs, counters, flags and input registers, and set the FSM to UNLOCKED.
REQ-029 SHALL treat reset mid-frame as a fresh start: the first frame after reset is discarded per REQ-021.

Structure
REQ-030 SHALL place the state-enum typedef and the 12-bit measurement width constant in the shared video package.
REQ-031 SHALL use one sub-module, edge_det, to register a signal and produce rise and fall pulses; it is instantiated for hs, vs and de.

Verification
Use H_WIDTH=8, H_TOTAL=12, V_HEIGHT=4, LOCK_FRAMES=3, TIMEOUT=24.
REQ-032 SHALL cover nominal lock: after reset, drive 5 correct frames -> locked_o rises one clock after the 4th vs rise, and readbacks show 8/12/4.
REQ-033 SHALL cover a short line: in locked state, one line has 7 de cycles -> err_o pulses once at the next vs rise, locked_o drops, and relocking takes 3 good frames.
REQ-034 SHALL cover a missing line: a frame with 3 lines in CHECKING -> counter resets and err_o pulses, with h_width_o=8 and v_height_o=3.
REQ-035 SHALL cover timeout: hs held low for 24 clocks while locked -> locked_o=0 and exactly one err_o pulse.
REQ-036 SHALL cover reset mid-frame: assert rst_i asynchronously mid-line -> outputs are 0 before the next clk_i edge, and the first post-reset frame does not count.
REQ-037 SHALL cover coincident edges and saturation: de rise together with vs rise counts in the new frame; de held high for 5000 clocks -> h_width_o=4095 and the frame is bad.

Source files
------------

// File: rtl/vid_lock_pkg.sv
// Shared video definitions: lock FSM states, measurement width and a
// saturating increment used by all measurement counters.
package vid_lock_pkg;

   localparam int MEAS_W = 12;
   localparam logic [MEAS_W-1:0] MEAS_MAX = '1;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      CHECKING = 2'd1,
      LOCKED   = 2'd2
   } lock_state_t;

   function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
      return (v == MEAS_MAX) ? v : v + MEAS_W'(1);
   endfunction

endpackage

// File: rtl/vid_lock_edge_det.sv
// Registers one video timing input and flags its rising and falling edges
// by comparing the registered value against its previous value.
module edge_det (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic sig_q;
   logic sig_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q <= 1'b0;
         sig_d <= 1'b0;
      end else begin
         sig_q <= sig_i;
         sig_d <= sig_q;
      end
   end

   assign rise_o = sig_q & ~sig_d;
   assign fall_o = ~sig_q & sig_d;

endmodule

// File: rtl/vid_lock.sv
// Video timing lock detector: measures line width, line period and frame
// height, and declares lock after enough consecutive matching frames.
module vid_lock
   import vid_lock_pkg::*;
#(
   parameter int H_WIDTH     = 1920,
   parameter int H_TOTAL     = 2200,
   parameter int V_HEIGHT    = 1080,
   parameter int LOCK_FRAMES = 4,
   parameter int TIMEOUT     = 2 * H_TOTAL
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              hs_i,
   input  logic              vs_i,
   input  logic              de_i,
   output logic              locked_o,
   output logic              frame_o,
   output logic              err_o,
   output logic [MEAS_W-1:0] h_width_o,
   output logic [MEAS_W-1:0] h_total_o,
   output logic [MEAS_W-1:0] v_height_o
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam int LC_W = $clog2(LOCK_FRAMES + 1);
   localparam logic [MEAS_W-1:0] H_WIDTH_C  = MEAS_W'(H_WIDTH);
   localparam logic [MEAS_W-1:0] H_TOTAL_C  = MEAS_W'(H_TOTAL);
   localparam logic [MEAS_W-1:0] V_HEIGHT_C = MEAS_W'(V_HEIGHT);
   localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0]   TO_DONE    = TO_W'(TIMEOUT);
   localparam logic [LC_W-1:0]   LC_LAST    = LC_W'(LOCK_FRAMES - 1);

   logic hs_rise, hs_fall_unused;
   logic vs_rise, vs_fall_unused;
   logic de_rise, de_fall;

   edge_det u_hs (.clk_i(clk_i), .rst_i(rst_i), .sig_i(hs_i), .rise_o(hs_rise), .fall_o(hs_fall_unused));
   edge_det u_vs (.clk_i(clk_i), .rst_i(rst_i), .sig_i(vs_i), .rise_o(vs_rise), .fall_o(vs_fall_unused));
   edge_det u_de (.clk_i(clk_i), .rst_i(rst_i), .sig_i(de_i), .rise_o(de_rise), .fall_o(de_fall));

   logic [MEAS_W-1:0] de_cnt, hs_cnt, line_cnt, last_width, last_period;
   logic              frame_bad, period_valid;
   logic [TO_W-1:0]   to_cnt;
   logic [LC_W-1:0]   good_cnt;
   lock_state_t       state;

   logic              width_err, period_err, timeout_hit, frame_good;
   logic [MEAS_W-1:0] cur_width, cur_period;

   // Mismatches seen in the vs-rise cycle itself still belong to the ending frame.
   assign width_err   = de_fall && ((de_cnt != H_WIDTH_C) || (de_cnt == MEAS_MAX));
   assign period_err  = hs_rise && period_valid && ((hs_cnt != H_TOTAL_C) || (hs_cnt == MEAS_MAX));
   assign timeout_hit = !hs_rise && (to_cnt == TO_LAST);
   assign frame_good  = !frame_bad && !width_err && !period_err &&
                        (line_cnt == V_HEIGHT_C) && (line_cnt != MEAS_MAX);
   assign cur_width   = de_fall ? de_cnt : last_width;
   assign cur_period  = (hs_rise && period_valid) ? hs_cnt : last_period;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         de_cnt       <= '0;
         hs_cnt       <= '0;
         line_cnt     <= '0;
         last_width   <= '0;
         last_period  <= '0;
         frame_bad    <= 1'b0;
         period_valid <= 1'b0;
         to_cnt       <= '0;
      end else begin
         de_cnt <= de_rise ? MEAS_W'(1) : sat_inc(de_cnt);
         if (de_fall)
            last_width <= de_cnt;

         if (hs_rise) begin
            hs_cnt       <= MEAS_W'(1);
            period_valid <= 1'b1;
            if (period_valid)
               last_period <= hs_cnt;
         end else begin
            hs_cnt <= sat_inc(hs_cnt);
         end

         // The idle counter parks at TIMEOUT so a long gap raises only one error.
         if (hs_rise)
            to_cnt <= '0;
         else if (to_cnt != TO_DONE)
            to_cnt <= to_cnt + TO_W'(1);
         if (timeout_hit)
            period_valid <= 1'b0;

         if (vs_rise) begin
            frame_bad <= 1'b0;
            line_cnt  <= de_rise ? MEAS_W'(1) : '0;
         end else begin
            if (width_err || period_err)
               frame_bad <= 1'b1;
            if (de_rise)
               line_cnt <= sat_inc(line_cnt);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= UNLOCKED;
         good_cnt   <= '0;
         locked_o   <= 1'b0;
         frame_o    <= 1'b0;
         err_o      <= 1'b0;
         h_width_o  <= '0;
         h_total_o  <= '0;
         v_height_o <= '0;
      end else begin
         frame_o <= vs_rise;
         err_o   <= 1'b0;
         if (vs_rise) begin
            h_width_o  <= cur_width;
            h_total_o  <= cur_period;
            v_height_o <= line_cnt;
         end

         if (timeout_hit) begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            locked_o <= 1'b0;
            err_o    <= 1'b1;
         end else if (vs_rise) begin
            case (state)
               UNLOCKED: begin
                  state    <= CHECKING;
                  good_cnt <= '0;
               end
               CHECKING: begin
                  if (frame_good) begin
                     good_cnt <= good_cnt + LC_W'(1);
                     if (good_cnt == LC_LAST) begin
                        state    <= LOCKED;
                        locked_o <= 1'b1;
                     end
                  end else begin
                     good_cnt <= '0;
                     err_o    <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (!frame_good) begin
                     state    <= CHECKING;
                     good_cnt <= '0;
                     locked_o <= 1'b0;
                     err_o    <= 1'b1;
                  end
               end
               default: begin
                  state    <= UNLOCKED;
                  good_cnt <= '0;
                  locked_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vid_lock.sv
// Randomized frame-level bench for vid_lock; a frame-descriptor model predicts
// lock status, error pulses and readbacks at every vs rise.
module tb_vid_lock;

   localparam int H_WIDTH     = 8;
   localparam int H_TOTAL     = 12;
   localparam int V_HEIGHT    = 4;
   localparam int LOCK_FRAMES = 3;
   localparam int TIMEOUT     = 24;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        hs_i = 1'b0, vs_i = 1'b0, de_i = 1'b0;
   logic        locked_o, frame_o, err_o;
   logic [11:0] h_width_o, h_total_o, v_height_o;

   int checks = 0;
   int errors = 0;

   vid_lock #(
      .H_WIDTH(H_WIDTH), .H_TOTAL(H_TOTAL), .V_HEIGHT(V_HEIGHT),
      .LOCK_FRAMES(LOCK_FRAMES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .hs_i(hs_i), .vs_i(vs_i), .de_i(de_i),
      .locked_o(locked_o), .frame_o(frame_o), .err_o(err_o),
      .h_width_o(h_width_o), .h_total_o(h_total_o), .v_height_o(v_height_o)
   );

   always #5 clk_i = ~clk_i;

   // Pulse counters observed away from the active edge.
   int err_seen = 0, frame_seen = 0;
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (err_o)   err_seen++;
         if (frame_o) frame_seen++;
      end
   end

   // Frame description for the next frame to drive, and the model of the last one.
   int n_act;
   int lw[8];
   bit coinc;
   int extra;
   int prev_w, prev_lines, prev_total;
   bit prev_good, prev_valid;
   bit synced;
   int streak;
   bit exp_locked, exp_err;
   int err_exp = 0, frame_exp = 0;

   task automatic model_unsync();
      synced = 0; streak = 0; exp_locked = 0; prev_valid = 0;
   endtask

   task automatic model_vs();
      if (!synced) begin
         synced = 1; streak = 0; exp_err = 0;
      end else if (prev_good) begin
         streak++; exp_err = 0;
      end else begin
         streak = 0; exp_err = 1;
      end
      exp_locked = synced && (streak >= LOCK_FRAMES);
      frame_exp++;
      if (exp_err) err_exp++;
   endtask

   task automatic drive_cycle(input logic h, input logic v, input logic d);
      @(posedge clk_i);
      #1;
      hs_i = h; vs_i = v; de_i = d;
   endtask

   task automatic drive_vs_line(input int de_w);
      bit lock_before;
      lock_before = exp_locked;
      for (int c = 0; c < H_TOTAL; c++) begin
         drive_cycle(c < 2, 1'b1, c < de_w);
         if (c == 1) begin
            checks++;
            if (locked_o !== lock_before || frame_o !== 1'b0) begin
               errors++;
               $display("[TB] FAIL pre_vs_edge: locked_o=%b frame_o=%b expected locked_o=%b frame_o=0",
                        locked_o, frame_o, lock_before);
            end
         end else if (c == 2) begin
            model_vs();
            checks++;
            if (frame_o !== 1'b1) begin
               errors++;
               $display("[TB] FAIL frame_pulse: frame_o=%b expected 1", frame_o);
            end
            checks++;
            if (err_o !== exp_err) begin
               errors++;
               $display("[TB] FAIL err_at_vs: err_o=%b expected %b", err_o, exp_err);
            end
            checks++;
            if (locked_o !== exp_locked) begin
               errors++;
               $display("[TB] FAIL locked_at_vs: locked_o=%b expected %b", locked_o, exp_locked);
            end
            if (prev_valid) begin
               checks++;
               if (h_width_o !== 12'(prev_w) || h_total_o !== 12'(prev_total) ||
                   v_height_o !== 12'(prev_lines)) begin
                  errors++;
                  $display("[TB] FAIL readback: w/t/h=%0d/%0d/%0d expected %0d/%0d/%0d",
                           h_width_o, h_total_o, v_height_o, prev_w, prev_total, prev_lines);
               end
            end
         end else if (c == 3) begin
            checks++;
            if (frame_o !== 1'b0 || err_o !== 1'b0) begin
               errors++;
               $display("[TB] FAIL pulse_width: frame_o=%b err_o=%b expected 0/0", frame_o, err_o);
            end
         end
      end
   endtask

   task automatic drive_body_line(input int start, input int w, input int len);
      for (int c = 0; c < len; c++)
         drive_cycle(c < 2, 1'b0, (c >= start) && (c < start + w));
   endtask

   task automatic drive_frame();
      bit good;
      if (coinc) begin
         drive_vs_line(lw[0]);
         for (int l = 1; l < n_act; l++) drive_body_line(0, lw[l], H_TOTAL);
         drive_body_line(0, 0, H_TOTAL);
         drive_body_line(0, 0, H_TOTAL + extra);
      end else begin
         drive_vs_line(0);
         for (int l = 0; l < n_act; l++) drive_body_line(3, lw[l], H_TOTAL);
         drive_body_line(0, 0, H_TOTAL + extra);
      end
      good = (n_act == V_HEIGHT) && (extra == 0);
      for (int l = 0; l < n_act; l++)
         if (lw[l] != H_WIDTH) good = 0;
      prev_w = lw[n_act-1]; prev_lines = n_act; prev_total = H_TOTAL + extra;
      prev_good = good; prev_valid = 1;
   endtask

   task automatic set_good();
      n_act = V_HEIGHT; coinc = 0; extra = 0;
      for (int l = 0; l < 8; l++) lw[l] = H_WIDTH;
   endtask

   task automatic do_reset();
      hs_i = 0; vs_i = 0; de_i = 0;
      rst_i = 1;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 0;
      model_unsync();
   endtask

   task automatic ensure_locked();
      for (int i = 0; i < 8 && !exp_locked; i++) begin
         set_good();
         drive_frame();
      end
   endtask

   task automatic test_reset();
      rst_i = 1; hs_i = 0; vs_i = 0; de_i = 0;
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if ({locked_o, frame_o, err_o, h_width_o, h_total_o, v_height_o} !== 39'd0) begin
         errors++;
         $display("[TB] FAIL reset_state: locked=%b frame=%b err=%b w/t/h=%0d/%0d/%0d expected all 0",
                  locked_o, frame_o, err_o, h_width_o, h_total_o, v_height_o);
      end
      rst_i = 0;
      model_unsync();
   endtask

   task automatic test_nominal();
      for (int f = 0; f < 5; f++) begin
         set_good();
         drive_frame();
      end
      checks++;
      if (locked_o !== 1'b1 || h_width_o !== 12'd8 || h_total_o !== 12'd12 || v_height_o !== 12'd4) begin
         errors++;
         $display("[TB] FAIL nominal_lock: locked=%b w/t/h=%0d/%0d/%0d expected 1 8/12/4",
                  locked_o, h_width_o, h_total_o, v_height_o);
      end
   endtask

   task automatic test_short_line();
      int e0;
      ensure_locked();
      e0 = err_seen;
      set_good();
      lw[$urandom_range(0, V_HEIGHT-1)] = H_WIDTH - 1;
      drive_frame();
      for (int f = 0; f < 4; f++) begin
         set_good();
         drive_frame();
      end
      checks++;
      if (err_seen - e0 !== 1 || locked_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL short_line: err pulses=%0d locked=%b expected 1 and 1", err_seen - e0, locked_o);
      end
   endtask

   task automatic test_missing_line();
      do_reset();
      set_good(); drive_frame();
      set_good(); drive_frame();
      set_good(); n_act = V_HEIGHT - 1; drive_frame();
      set_good(); drive_frame();
      checks++;
      if (h_width_o !== 12'd8 || v_height_o !== 12'd3 || locked_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL missing_line: w=%0d h=%0d locked=%b expected 8 3 0",
                  h_width_o, v_height_o, locked_o);
      end
      for (int f = 0; f < 3; f++) begin
         set_good();
         drive_frame();
      end
      checks++;
      if (locked_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL relock_after_missing: locked=%b expected 1", locked_o);
      end
   endtask

   task automatic test_timeout();
      int e0;
      ensure_locked();
      e0 = err_seen;
      for (int i = 0; i < 60; i++) drive_cycle(1'b0, 1'b0, 1'b0);
      err_exp++;
      model_unsync();
      checks++;
      if (err_seen - e0 !== 1 || locked_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout: err pulses=%0d locked=%b expected 1 and 0", err_seen - e0, locked_o);
      end
      for (int f = 0; f < 4; f++) begin
         set_good();
         drive_frame();
      end
   endtask

   task automatic test_reset_mid();
      ensure_locked();
      set_good();
      drive_vs_line(0);
      drive_body_line(3, H_WIDTH, 6);
      #3;
      checks++;
      if (locked_o !== exp_locked) begin
         errors++;
         $display("[TB] FAIL pre_reset_lock: locked=%b expected %b", locked_o, exp_locked);
      end
      rst_i = 1;
      #1;
      checks++;
      if ({locked_o, frame_o, err_o, h_width_o, h_total_o, v_height_o} !== 39'd0) begin
         errors++;
         $display("[TB] FAIL async_reset: locked=%b frame=%b err=%b w/t/h=%0d/%0d/%0d expected all 0",
                  locked_o, frame_o, err_o, h_width_o, h_total_o, v_height_o);
      end
      hs_i = 0; vs_i = 0; de_i = 0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 0;
      model_unsync();
      for (int f = 0; f < 4; f++) begin
         set_good();
         drive_frame();
      end
   endtask

   task automatic test_coincident();
      int e0;
      ensure_locked();
      e0 = err_seen;
      for (int f = 0; f < 4; f++) begin
         set_good();
         coinc = 1;
         drive_frame();
      end
      set_good();
      drive_frame();
      checks++;
      if (err_seen - e0 !== 0 || locked_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL coincident: err pulses=%0d locked=%b expected 0 and 1", err_seen - e0, locked_o);
      end
   endtask

   task automatic test_saturation();
      ensure_locked();
      drive_vs_line(0);
      for (int k = 0; k < 5004; k++)
         drive_cycle((k % H_TOTAL) < 2, 1'b0, (k >= 3) && (k < 5003));
      drive_body_line(0, 0, H_TOTAL);
      prev_w = 4095; prev_lines = 1; prev_total = H_TOTAL; prev_good = 0; prev_valid = 1;
      set_good();
      drive_frame();
      checks++;
      if (h_width_o !== 12'd4095 || v_height_o !== 12'd1 || locked_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL saturation: w=%0d h=%0d locked=%b expected 4095 1 0",
                  h_width_o, v_height_o, locked_o);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 30; f++) begin
         int kind;
         kind = int'($urandom_range(0, 4));
         set_good();
         coinc = bit'($urandom_range(0, 1));
         case (kind)
            2: lw[$urandom_range(0, V_HEIGHT-1)] = int'($urandom_range(1, H_WIDTH));
            3: n_act = int'($urandom_range(3, 5));
            4: extra = int'($urandom_range(1, 3));
            default: ;
         endcase
         drive_frame();
      end
      set_good();
      drive_frame();
   endtask

   task automatic test_pulse_totals();
      drive_cycle(1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b0, 1'b0);
      checks++;
      if (err_seen !== err_exp || frame_seen !== frame_exp) begin
         errors++;
         $display("[TB] FAIL pulse_totals: err=%0d frame=%0d expected %0d %0d",
                  err_seen, frame_seen, err_exp, frame_exp);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_short_line();
      test_missing_line();
      test_timeout();
      test_reset_mid();
      test_coincident();
      test_saturation();
      test_random();
      test_pulse_totals();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
